// File: rtl/banco_registradores_sb_if.sv
// banco_registradores_sb_if: register-file access bus (two read ports, one write port, one reservation port)
interface banco_registradores_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] rs;
  logic [ADDR_WIDTH-1:0] rt;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] dado_escrita;
  logic                  RegReserve;
  logic [ADDR_WIDTH-1:0] rd_reserve;
  logic [DATA_WIDTH-1:0] dado_lido1;
  logic [DATA_WIDTH-1:0] dado_lido2;
  logic                  busy1;
  logic                  busy2;
  modport master (
    output RegWrite, rs, rt, rd, dado_escrita, RegReserve, rd_reserve,
    input  dado_lido1, dado_lido2, busy1, busy2
  );
  modport slave (
    input  RegWrite, rs, rt, rd, dado_escrita, RegReserve, rd_reserve,
    output dado_lido1, dado_lido2, busy1, busy2
  );
endinterface

// File: rtl/banco_registradores_sb.sv
// banco_registradores_sb: register file with per-register busy (scoreboard) bits; define BANCO_REGISTRADORES_BYPASS_EN for write-through read bypass
module banco_registradores_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                    clock,
  input logic                    reset,
  banco_registradores_sb_if.slave bus
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [N];
  logic [N-1:0]          busy;
  logic                  byp1;
  logic                  byp2;
  // Register 0 is never written or reserved, so it reads 0 and idle without a read-side mux.
  // A reservation is applied after the write so a same-edge reserve of the same register wins.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (bus.RegWrite && bus.rd != '0) begin
        regs[bus.rd] <= bus.dado_escrita;
        busy[bus.rd] <= 1'b0;
      end
      if (bus.RegReserve && bus.rd_reserve != '0) busy[bus.rd_reserve] <= 1'b1;
    end
`ifdef BANCO_REGISTRADORES_BYPASS_EN
  assign byp1 = reset && bus.RegWrite && bus.rd != '0 && bus.rs == bus.rd;
  assign byp2 = reset && bus.RegWrite && bus.rd != '0 && bus.rt == bus.rd;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign bus.dado_lido1 = byp1 ? bus.dado_escrita : regs[bus.rs];
  assign bus.dado_lido2 = byp2 ? bus.dado_escrita : regs[bus.rt];
  assign bus.busy1      = !byp1 && busy[bus.rs];
  assign bus.busy2      = !byp2 && busy[bus.rt];
endmodule

// File: tb/tb_banco_registradores_sb.sv
// tb_banco_registradores_sb: table-driven directed checks of the scoreboarded register file
module tb_banco_registradores_sb;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  banco_registradores_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  banco_registradores_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] din;
    logic        res;
    logic [4:0]  rres;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
  } vec_t;
  vec_t vecs [13];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    bus.RegWrite   = 1'b0;
    bus.RegReserve = 1'b0;
  endtask
  initial begin
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd1,  5'd31, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd4,  32'h8,        1'b0, 5'd0,  5'd4,  5'd4,  32'h8,        32'h8,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'hF,        1'b0, 5'd0,  5'd0,  5'd4,  32'h0,        32'h8,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  5'd6,  5'd4,  32'h0,        32'h8,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd6,  32'hF,        1'b1, 5'd6,  5'd6,  5'd6,  32'hF,        32'hF,        1'b1, 1'b1};
    vecs[6]  = '{1'b1, 5'd6,  32'hF,        1'b0, 5'd0,  5'd6,  5'd6,  32'hF,        32'hF,        1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd10, 32'hDEAD,     1'b1, 5'd12, 5'd10, 5'd12, 32'hDEAD,     32'h0,        1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 5'd12, 5'd10, 32'h0,        32'hDEAD,     1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'd10, 32'h1234,     1'b0, 5'd0,  5'd10, 5'd12, 32'h1234,     32'h0,        1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'd12, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd12, 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'd31, 32'h80000001, 1'b0, 5'd0,  5'd31, 5'd0,  32'h80000001, 32'h0,        1'b0, 1'b0};
    vecs[12] = '{1'b1, 5'd3,  32'h5,        1'b0, 5'd0,  5'd3,  5'd31, 32'h5,        32'h80000001, 1'b0, 1'b0};
    idle();
    bus.rd = '0; bus.rd_reserve = '0; bus.dado_escrita = '0;
    bus.rs = 5'd5; bus.rt = 5'd9;
    #2;
    check("reset_d1", bus.dado_lido1, 32'h0);
    check("reset_d2", bus.dado_lido2, 32'h0);
    check("reset_b1", {31'b0, bus.busy1}, 32'h0);
    check("reset_b2", {31'b0, bus.busy2}, 32'h0);
    #10 reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.RegWrite = vecs[i].we; bus.rd = vecs[i].rd; bus.dado_escrita = vecs[i].din;
      bus.RegReserve = vecs[i].res; bus.rd_reserve = vecs[i].rres;
      tick();
      idle();
      bus.rs = vecs[i].rs; bus.rt = vecs[i].rt;
      #1;
      check($sformatf("v%0d_d1", i), bus.dado_lido1, vecs[i].e1);
      check($sformatf("v%0d_d2", i), bus.dado_lido2, vecs[i].e2);
      check($sformatf("v%0d_b1", i), {31'b0, bus.busy1}, {31'b0, vecs[i].eb1});
      check($sformatf("v%0d_b2", i), {31'b0, bus.busy2}, {31'b0, vecs[i].eb2});
    end
    bus.RegWrite = 1'b1; bus.rd = 5'd3; bus.dado_escrita = 32'h9; bus.rs = 5'd3; bus.rt = 5'd3;
    #1;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    check("bypass_pre_d1", bus.dado_lido1, 32'h9);
`else
    check("bypass_pre_d1", bus.dado_lido1, 32'h5);
`endif
    check("bypass_pre_b1", {31'b0, bus.busy1}, 32'h0);
    tick();
    idle();
    check("bypass_post_d1", bus.dado_lido1, 32'h9);
    check("bypass_post_d2", bus.dado_lido2, 32'h9);
    bus.RegWrite = 1'b1; bus.rd = 5'd7; bus.dado_escrita = 32'hA5;
    bus.RegReserve = 1'b1; bus.rd_reserve = 5'd7;
    tick();
    idle();
    bus.rs = 5'd7; bus.rt = 5'd3;
    #1;
    check("r7_d1", bus.dado_lido1, 32'hA5);
    check("r7_b1", {31'b0, bus.busy1}, 32'h1);
    reset = 1'b0;
    #1;
    check("async_rst_d1", bus.dado_lido1, 32'h0);
    check("async_rst_b1", {31'b0, bus.busy1}, 32'h0);
    check("async_rst_d2", bus.dado_lido2, 32'h0);
    bus.RegWrite = 1'b1; bus.rd = 5'd7; bus.dado_escrita = 32'h55;
    bus.RegReserve = 1'b1; bus.rd_reserve = 5'd7;
    #1;
    check("in_rst_pre_d1", bus.dado_lido1, 32'h0);
    tick();
    check("in_rst_d1", bus.dado_lido1, 32'h0);
    check("in_rst_b1", {31'b0, bus.busy1}, 32'h0);
    reset = 1'b1;
    tick();
    idle();
    #1;
    check("resume_d1", bus.dado_lido1, 32'h55);
    check("resume_b1", {31'b0, bus.busy1}, 32'h1);
    bus.RegWrite = 1'b1; bus.rd = 5'd9; bus.dado_escrita = 32'h77;
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    idle();
    tick();
    bus.rs = 5'd9; bus.rt = 5'd7;
    #1;
    check("mid_rst_d1", bus.dado_lido1, 32'h0);
    check("mid_rst_b2", {31'b0, bus.busy2}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
